// File: rtl/idf_pkg.sv
// Shared types and helpers for the inertial-delay filter and other
// primitive-library monitors.
package idf_pkg;

  typedef enum logic [1:0] {
    LO     = 2'd0,
    PEND_R = 2'd1,
    HI     = 2'd2,
    PEND_F = 2'd3
  } filt_state_e;

  localparam int MAX_DLY = 255;
  localparam int POP_W   = 256;

  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/inertial_delay_filter_if.sv
// Channel bundle for the inertial-delay filter.
// No backpressure: every edge with en high samples d_in; outputs are
// registered and valid every cycle, dbg_state packs 2 bits per channel.
interface inertial_delay_filter_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 16
) ();
  logic               en;
  logic [WIDTH-1:0]   d_in;
  logic               clr_count;
  logic [WIDTH-1:0]   d_out;
  logic [WIDTH-1:0]   glitch;
  logic [CNT_W-1:0]   rej_count;
  logic [2*WIDTH-1:0] dbg_state;

  modport master (
    output en, d_in, clr_count,
    input  d_out, glitch, rej_count, dbg_state
  );

  modport slave (
    input  en, d_in, clr_count,
    output d_out, glitch, rej_count, dbg_state
  );
endinterface

// File: rtl/idf_channel.sv
// One channel of the inertial-delay filter: level FSM, delay counter and
// a registered one-cycle glitch flag when a pending edge is cancelled.
module idf_channel
  import idf_pkg::*;
#(
  parameter int RISE_DLY = 2,
  parameter int FALL_DLY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic        i_d,
  output logic        o_d,
  output logic        o_glitch,
  output logic        o_glitch_next,
  output filt_state_e o_state
);

  localparam int MAXD = (RISE_DLY > FALL_DLY) ? RISE_DLY : FALL_DLY;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic [CW:0] RISE_C = (CW+1)'(RISE_DLY);
  localparam logic [CW:0] FALL_C = (CW+1)'(FALL_DLY);

  filt_state_e   r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic          r_out, w_out_n;
  logic          r_glitch, w_glitch_n;
  logic [CW:0]   w_cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LO;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_out    <= w_out_n;
      r_glitch <= w_glitch_n;
    end
  end

  // The cnt-th consecutive sample is the one being evaluated; the edge that
  // brings the count to DLY is the one that commits the new level.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_out_n    = r_out;
    w_glitch_n = 1'b0;
    w_cnt_inc  = {1'b0, r_cnt} + 1'b1;
    if (i_en) begin
      unique case (r_state)
        LO: if (i_d) begin
          if (RISE_C == 1) begin
            w_state_n = HI;
            w_out_n   = 1'b1;
            w_cnt_n   = '0;
          end else begin
            w_state_n = PEND_R;
            w_cnt_n   = CW'(1);
          end
        end
        PEND_R: if (i_d) begin
          if (w_cnt_inc >= RISE_C) begin
            w_state_n = HI;
            w_out_n   = 1'b1;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n   = w_cnt_inc[CW-1:0];
          end
        end else begin
          w_state_n  = LO;
          w_cnt_n    = '0;
          w_glitch_n = 1'b1;
        end
        HI: if (!i_d) begin
          if (FALL_C == 1) begin
            w_state_n = LO;
            w_out_n   = 1'b0;
            w_cnt_n   = '0;
          end else begin
            w_state_n = PEND_F;
            w_cnt_n   = CW'(1);
          end
        end
        PEND_F: if (!i_d) begin
          if (w_cnt_inc >= FALL_C) begin
            w_state_n = LO;
            w_out_n   = 1'b0;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n   = w_cnt_inc[CW-1:0];
          end
        end else begin
          w_state_n  = HI;
          w_cnt_n    = '0;
          w_glitch_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_d           = r_out;
  assign o_glitch      = r_glitch;
  assign o_glitch_next = w_glitch_n;
  assign o_state       = r_state;

endmodule

// File: rtl/inertial_delay_filter.sv
// WIDTH-channel inertial-delay filter; the top level only accumulates the
// saturating count of rejected glitches across all channels.
module inertial_delay_filter
  import idf_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int RISE_DLY = 2,
  parameter int FALL_DLY = 1,
  parameter int CNT_W    = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  inertial_delay_filter_if.slave bus
);

  if (RISE_DLY < 1 || RISE_DLY > MAX_DLY) begin : g_bad_rise
    $error("inertial_delay_filter: RISE_DLY out of range 1..255");
  end
  if (FALL_DLY < 1 || FALL_DLY > MAX_DLY) begin : g_bad_fall
    $error("inertial_delay_filter: FALL_DLY out of range 1..255");
  end

  localparam int SUM_W = CNT_W + $clog2(WIDTH + 1);
  localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

  logic [WIDTH-1:0]   w_d_out;
  logic [WIDTH-1:0]   w_glitch;
  logic [WIDTH-1:0]   w_glitch_n;
  logic [2*WIDTH-1:0] w_dbg;
  logic [POP_W-1:0]   w_pop_vec;
  logic [SUM_W-1:0]   w_sum;
  logic [CNT_W-1:0]   r_rej;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    filt_state_e w_state;
    idf_channel #(
      .RISE_DLY (RISE_DLY),
      .FALL_DLY (FALL_DLY)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_en          (bus.en),
      .i_d           (bus.d_in[g]),
      .o_d           (w_d_out[g]),
      .o_glitch      (w_glitch[g]),
      .o_glitch_next (w_glitch_n[g]),
      .o_state       (w_state)
    );
    assign w_dbg[2*g +: 2] = w_state;
  end

  always_comb begin
    w_pop_vec             = '0;
    w_pop_vec[WIDTH-1:0]  = w_glitch_n;
    w_sum = SUM_W'(r_rej) + SUM_W'(popcount(w_pop_vec));
  end

  // Clear outranks same-edge rejections; clear works even with en low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rej <= '0;
    end else if (bus.clr_count) begin
      r_rej <= '0;
    end else if (bus.en) begin
      r_rej <= (w_sum > SAT) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign bus.d_out     = w_d_out;
  assign bus.glitch    = w_glitch;
  assign bus.rej_count = r_rej;
  assign bus.dbg_state = w_dbg;

endmodule

// File: doc/inertial_delay_filter.md
Name: inertial_delay_filter

Overview:
- Synchronous receiver-side model of gate inertial delay for the gate-level primitive library.
- Filters each bit of a WIDTH-bit input vector so that only levels held for at least RISE_DLY sampled cycles (0->1) or FALL_DLY sampled cycles (1->0) propagate to the output.
- Shorter pulses are swallowed and counted.
- Sits at the clocked boundary downstream of gate-level logic outputs, giving the clocked domain a clean, glitch-free view with a per-channel rejection report.

Parameters:
WIDTH, 2, number of independent channels
RISE_DLY, 2, consecutive high samples required before output rises; legal range 1..255
FALL_DLY, 1, consecutive low samples required before output falls; legal range 1..255
CNT_W, 16, width of the saturating rejected-glitch counter

Ports:
clk  input  1  sampling clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  sample enable; when low, all state, counters and outputs hold
d_in  input  WIDTH  raw channel levels, sampled on clk
clr_count  input  1  synchronous clear of rej_count
d_out  output  WIDTH  filtered levels
glitch  output  WIDTH  one-cycle pulse per channel on the edge a pending transition is cancelled
rej_count  output  CNT_W  total rejected glitches across all channels, saturating

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values (rst_n low, asynchronous):
  - d_out = 0, glitch = 0, rej_count = 0.
  - Every channel goes to state LO with its delay counter = 0.
  - Any pending transition is discarded, including one in progress mid-delay.
- Per-channel FSM. States are LO, PEND_R, HI, PEND_F, evaluated only on rising clk edges with en = 1.
- LO:
  - d_in = 1 -> go to PEND_R with cnt = 1.
  - If RISE_DLY = 1, go directly to HI instead (d_out = 1 after this edge).
- PEND_R:
  - d_in = 1 and cnt+1 < RISE_DLY -> cnt increments.
  - d_in = 1 and cnt+1 = RISE_DLY -> go to HI, d_out = 1.
  - d_in = 0 -> go to LO, cnt = 0, glitch[i] = 1 for exactly this cycle.
- HI and PEND_F: mirror of LO and PEND_R, using FALL_DLY and d_out = 0.
- Latency: a level first sampled at edge k appears on d_out after edge k+DLY-1. With defaults:
  - rise = 2 cycles from the first high sample;
  - fall = 1 cycle, i.e. a registered pass-through.
- Pulse rejection: a high pulse spanning fewer than RISE_DLY sampled edges never reaches d_out. Pulses between samples are invisible; no asynchronous detection.
- en = 0:
  - FSM, cnt, d_out and rej_count hold.
  - glitch is driven 0.
  - clr_count is still honoured.
- rej_count:
  - On each enabled edge, adds popcount(glitch_next), i.e. the number of channels cancelling on that edge.
  - Saturates at 2^CNT_W-1; never wraps.
- Simultaneous clr_count and rejections: clear wins, rej_count = 0 on that edge and those rejections are lost.
- d_out, glitch and rej_count are all registered; no combinational path from d_in.
- Counter width is derived as clog2(max(RISE_DLY, FALL_DLY)+1).
- Illegal DLY values (0 or above 255) fail at elaboration.

Decomposition:
- Shared package idf_pkg:
  - enum filt_state_e {LO, PEND_R, HI, PEND_F} (2 bits);
  - constant MAX_DLY = 255;
  - a popcount function reused by other primitive-library monitors.
- Sub-module idf_channel holds one channel's FSM, delay counter and glitch flag. It is instantiated WIDTH times by generate.
- The top level owns only rej_count accumulation, saturation and clear.

Test Plan:
1. Defaults. d_in[0] goes high at edge 5 and stays -> d_out[0] = 1 after edge 6. Falls at edge 10 -> d_out[0] = 0 after edge 10. glitch stays 0, rej_count = 0.
2. d_in[0] high for a single sampled edge (edge 5 only) -> d_out stays 0, glitch[0] = 1 for the cycle after edge 6, rej_count = 1.
3. Both channels glitch high on the same edge with RISE_DLY = 3, each held 2 edges -> glitch = 2'b11 for one cycle, rej_count goes 0 -> 2 in a single step.
4. Preload rej_count = 0xFFFE (CNT_W = 16) and generate 3 glitches -> rej_count = 0xFFFF and holds. Then assert clr_count together with a glitch -> rej_count = 0.
5. en = 0 while in PEND_R with cnt = 1 for 4 cycles, d_in varying -> no change. Raise en with d_in = 1 -> d_out rises on that edge (RISE_DLY = 2).
6. rst_n pulsed low asynchronously mid-clock while channel 1 is in PEND_F with d_out[1] = 1 -> d_out = 0, rej_count = 0 immediately. The pending fall yields no glitch after release.
